// File: rtl/prog_load_ctrl.sv
// Program-load controller: holds the core in reset, packs UART bytes little-endian
// into 32-bit words for the instruction memory, then releases the core to run from 0.
module prog_load_ctrl #(
  parameter int ADDR_W    = 14,
  parameter int MAX_WORDS = 16384,
  parameter int TIMEOUT   = 1000000,
  parameter int RST_HOLD  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_load,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              cpu_rst,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX_WORDS - 1);
  localparam logic [ADDR_W:0]   WC_ONE    = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [1:0]        byte_cnt, byte_cnt_nx;
  logic [TMR_W-1:0]  timer, timer_nx;
  logic [HOLD_W-1:0] hold, hold_nx;
  logic              got_byte, got_nx;
  logic [31:0]       wbuf, wbuf_nx;
  logic [31:0]       word_asm, wr_word;
  logic              wr_issue;
  logic              cpu_rst_nx, we_nx, busy_nx, done_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [31:0]       wdata_nx;
  logic [ADDR_W:0]   wc_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    byte_cnt_nx = byte_cnt;
    timer_nx    = timer;
    hold_nx     = hold;
    got_nx      = got_byte;
    wbuf_nx     = wbuf;
    wr_issue    = 1'b0;
    wr_word     = wbuf;
    addr_nx     = imem_addr;
    wdata_nx    = imem_wdata;
    wc_nx       = word_count;
    word_asm    = wbuf | ({24'd0, rx_byte} << {byte_cnt, 3'b000});

    unique case (state)
      ST_RUN: begin
        if (start_load) begin
          state_nx    = ST_LOAD;
          byte_cnt_nx = 2'd0;
          timer_nx    = '0;
          got_nx      = 1'b0;
          wbuf_nx     = '0;
          wc_nx       = '0;
          addr_nx     = '0;
        end
      end
      ST_LOAD: begin
        if (rx_valid) begin
          got_nx   = 1'b1;
          timer_nx = '0;
          if (byte_cnt == 2'd3) begin
            // The completing byte goes straight into the write; the buffer
            // restarts empty so a byte in the write cycle becomes byte 0.
            wr_issue    = 1'b1;
            wr_word     = word_asm;
            byte_cnt_nx = 2'd0;
            wbuf_nx     = '0;
            if (word_count[ADDR_W-1:0] == ADDR_LAST) begin
              state_nx = ST_DONE;
              hold_nx  = '0;
            end
          end else begin
            wbuf_nx     = word_asm;
            byte_cnt_nx = byte_cnt + 2'd1;
          end
        end else if (got_byte) begin
          if (timer == TMR_LAST) begin
            if (byte_cnt != 2'd0) begin
              wr_issue    = 1'b1;
              wr_word     = wbuf;
              byte_cnt_nx = 2'd0;
              wbuf_nx     = '0;
            end
            state_nx = ST_DONE;
            hold_nx  = '0;
          end else if (timer != TMR_MAX) begin
            timer_nx = timer + TMR_ONE;
          end
        end
      end
      ST_DONE: begin
        if (hold == HOLD_LAST) state_nx = ST_RUN;
        else                   hold_nx  = hold + HOLD_ONE;
      end
      default: state_nx = ST_RUN;
    endcase

    if (wr_issue) begin
      addr_nx  = word_count[ADDR_W-1:0];
      wdata_nx = wr_word;
      wc_nx    = word_count + WC_ONE;
    end
    we_nx      = wr_issue;
    cpu_rst_nx = (state_nx != ST_RUN);
    busy_nx    = (state_nx != ST_RUN);
    done_nx    = (state_nx == ST_DONE) && (state != ST_DONE);
  end

  // Registered outputs and datapath state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rst    <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
      byte_cnt   <= 2'd0;
      timer      <= '0;
      hold       <= '0;
      got_byte   <= 1'b0;
      wbuf       <= '0;
    end else begin
      cpu_rst    <= cpu_rst_nx;
      imem_we    <= we_nx;
      imem_addr  <= addr_nx;
      imem_wdata <= wdata_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      word_count <= wc_nx;
      byte_cnt   <= byte_cnt_nx;
      timer      <= timer_nx;
      hold       <= hold_nx;
      got_byte   <= got_nx;
      wbuf       <= wbuf_nx;
    end
  end

endmodule
